// File: rtl/mdu_divider_pkg.sv
// Shared types and constants for the iterative RV32M divide/remainder unit.
package mdu_divider_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int DIV_ITER     = XLEN_DEFAULT;

    typedef enum logic [1:0] {
        MD_DIV  = 2'd0,
        MD_DIVU = 2'd1,
        MD_REM  = 2'd2,
        MD_REMU = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic is_signed_op(input md_op_t o);
        return (o == MD_DIV) || (o == MD_REM);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider, one quotient bit per cycle, with divide-by-zero and signed
// overflow resolved at accept time and the sign fix applied on the output side.
module mdu_divider
    import mdu_divider_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic [1:0]      dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; flush suppresses the request-side transfer in the same cycle.

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvsr;
    md_op_t          op_q;
    logic            neg_q;
    logic            neg_r;

    logic            accept;
    logic            signed_in;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        signed_in = is_signed_op(md_op_t'(op));
        a_abs     = (signed_in && dividend[XLEN-1]) ? -dividend : dividend;
        b_abs     = (signed_in && divisor[XLEN-1])  ? -divisor  : divisor;
        div_zero  = (divisor == '0);
        ovf       = signed_in && (dividend == INT_MIN) && (divisor == '1);
    end

    // The partial remainder is shifted into XLEN+1 bits so divisors with the top
    // bit set still compare correctly.
    always_comb begin
        shifted  = {rem, quo[XLEN-1]};
        diff     = shifted - {1'b0, dvsr};
        ge       = !diff[XLEN];
        rem_step = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_step = {quo[XLEN-2:0], ge};
    end

    always_comb begin
        q_fix  = neg_q ? -quo : quo;
        r_fix  = neg_r ? -rem : rem;
        result = '0;
        if (out_valid) result = op_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            quo   <= '0;
            rem   <= '0;
            dvsr  <= '0;
            op_q  <= MD_DIV;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else if (accept) begin
            op_q  <= md_op_t'(op);
            count <= '0;
            dvsr  <= b_abs;
            if (div_zero) begin
                quo   <= '1;
                rem   <= dividend;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= DONE;
            end else if (ovf) begin
                quo   <= INT_MIN;
                rem   <= '0;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= DONE;
            end else begin
                quo   <= a_abs;
                rem   <= '0;
                neg_q <= signed_in && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                neg_r <= signed_in && dividend[XLEN-1];
                state <= BUSY;
            end
        end else begin
            case (state)
                BUSY: begin
                    quo   <= quo_step;
                    rem   <= rem_step;
                    count <= count + CW'(1);
                    if (count == LAST_STEP) state <= DONE;
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
